ospi_flash_arbiter: RTL and testbench

Two-port command arbiter and sequencer placed in front of `ospi_flash`. It accepts read/write/erase requests from two independent requesters, grants one at a time in round-robin order, and drives the flash command port with a fixed chip-select/enable/wait sequence. Each accepted request receives exactly one tagged response.

---
 rtl/ospi_flash_arbiter.sv | 139 +++++++++++++
 tb/tb_ospi_flash_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ospi_flash_arbiter.sv
// Two-requester round-robin command arbiter sequencing read/write/erase commands
// onto the ospi_flash command port, returning one tagged response per request.
module ospi_flash_arbiter #(
    parameter int RD_CYCLES = 4,
    parameter int WR_CYCLES = 8,
    parameter int ER_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_op0,
    input  logic [1:0]  req_op1,
    input  logic [23:0] req_addr0,
    input  logic [23:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        hold_req,
    output logic        flash_cs_n,
    output logic        flash_hold_n,
    output logic        flash_write_enable,
    output logic        flash_read_enable,
    output logic        flash_erase_enable,
    output logic [23:0] flash_address,
    output logic [31:0] flash_data_in,
    input  logic [31:0] flash_data_out
);

    localparam int MAX_RW = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int MAX_C  = (MAX_RW > ER_CYCLES) ? MAX_RW : ER_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {IDLE, SETUP, CMD, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic [1:0]    op_q;
    logic [23:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          id_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] op_cycles;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          grant_id;
    logic          accept;
    logic [1:0]    acc_op;
    logic [23:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          last_wait;

    // Tie goes to the requester that was not served last.
    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        req_ready = '0;
        if (state == IDLE && reset_n && (|req_valid))
            req_ready = grant_id ? 2'b10 : 2'b01;
        accept    = |(req_valid & req_ready);
        acc_op    = grant_id ? req_op1    : req_op0;
        acc_addr  = grant_id ? req_addr1  : req_addr0;
        acc_wdata = grant_id ? req_wdata1 : req_wdata0;
    end

    always_comb begin
        case (op_q)
            2'b00:   op_cycles = CW'(RD_CYCLES);
            2'b01:   op_cycles = CW'(WR_CYCLES);
            default: op_cycles = CW'(ER_CYCLES);
        endcase
    end

    always_comb begin
        state_nxt = state;
        last_wait = (state == WAIT) && !hold_req && (cnt == CW'(1));
        case (state)
            IDLE:    if (accept) state_nxt = (acc_op == 2'b11) ? DONE : SETUP;
            SETUP:   state_nxt = CMD;
            CMD:     state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        flash_cs_n         = !(state == SETUP || state == CMD || state == WAIT);
        flash_hold_n       = !(state == WAIT && hold_req);
        flash_read_enable  = (state == CMD) && (op_q == 2'b00);
        flash_write_enable = (state == CMD) && (op_q == 2'b01);
        flash_erase_enable = (state == CMD) && (op_q == 2'b10);
        rsp_valid          = (state == DONE);
        rsp_id             = id_q;
        rsp_rdata          = rdata_q;
        rsp_err            = err_q;
        flash_address      = addr_q;
        flash_data_in      = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= 1'b0;
            cnt        <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= acc_op;
                addr_q     <= acc_addr;
                wdata_q    <= acc_wdata;
                id_q       <= grant_id;
                last_grant <= grant_id;
                rdata_q    <= '0;
                err_q      <= (acc_op == 2'b11);
            end
            if (state == CMD) begin
                cnt <= op_cycles;
            end else if (state == WAIT && !hold_req) begin
                cnt <= cnt - CW'(1);
                // Read data is only meaningful on the final unheld WAIT cycle.
                if (last_wait)
                    rdata_q <= (op_q == 2'b00) ? flash_data_out : '0;
            end
        end
    end

endmodule

// File: tb/tb_ospi_flash_arbiter.sv
// Directed self-checking bench for ospi_flash_arbiter with default cycle counts
// (read 4, write 8, erase 32).
module tb_ospi_flash_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0, req_op1;
    logic [23:0] req_addr0, req_addr1;
    logic [31:0] req_wdata0, req_wdata1;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        hold_req;
    logic        flash_cs_n;
    logic        flash_hold_n;
    logic        flash_write_enable, flash_read_enable, flash_erase_enable;
    logic [23:0] flash_address;
    logic [31:0] flash_data_in;
    logic [31:0] flash_data_out;

    int n_checks = 0;
    int n_errors = 0;

    ospi_flash_arbiter #(.RD_CYCLES(4), .WR_CYCLES(8), .ER_CYCLES(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hold_req(hold_req),
        .flash_cs_n(flash_cs_n), .flash_hold_n(flash_hold_n),
        .flash_write_enable(flash_write_enable), .flash_read_enable(flash_read_enable),
        .flash_erase_enable(flash_erase_enable),
        .flash_address(flash_address), .flash_data_in(flash_data_in),
        .flash_data_out(flash_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle T+1 after an accept edge; runs until the response cycle.
    // lat counts cycles since accept; flash_data_out = base (+ lat when vary).
    task automatic observe(input int hs, input int hl, input logic [31:0] base, input bit vary,
                           output int lat, output int en_cyc, output int n_en,
                           output logic [2:0] en_mask, output int n_hold_low,
                           output logic [31:0] wdata_seen);
        lat = 1; en_cyc = 0; n_en = 0; en_mask = '0; n_hold_low = 0; wdata_seen = '0;
        forever begin
            hold_req       = (lat >= hs) && (lat < hs + hl);
            flash_data_out = vary ? base + 32'(lat) : base;
            #1;
            if (rsp_valid || lat >= 100) break;
            if (flash_read_enable || flash_write_enable || flash_erase_enable) begin
                n_en += int'(flash_read_enable) + int'(flash_write_enable) + int'(flash_erase_enable);
                en_mask |= {flash_erase_enable, flash_write_enable, flash_read_enable};
                if (en_cyc == 0) en_cyc = lat;
                wdata_seen = flash_data_in;
            end
            if (!flash_hold_n) n_hold_low++;
            tick();
            lat++;
        end
        hold_req = 1'b0;
    endtask

    int          lat, en_cyc, n_en, n_hold_low, n_rsp;
    logic [2:0]  en_mask;
    logic [31:0] wseen;

    initial begin
        reset_n = 1'b0; req_valid = '0; req_op0 = '0; req_op1 = '0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        hold_req = 1'b0; flash_data_out = '0;
        tick(); tick();

        // Reset state
        check("rst_ready", 64'(req_ready), 64'(2'b00));
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_cs_n", 64'(flash_cs_n), 64'd1);
        check("rst_hold_n", 64'(flash_hold_n), 64'd1);
        check("rst_enables", 64'({flash_erase_enable, flash_write_enable, flash_read_enable}), 64'd0);
        check("rst_addr", 64'(flash_address), 64'd0);
        check("rst_data_in", 64'(flash_data_in), 64'd0);

        // Read on requester 0
        reset_n = 1'b1;
        req_valid = 2'b01; req_op0 = 2'b00; req_addr0 = 24'h000100;
        #1;
        check("rd_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        check("rd_setup_cs", 64'(flash_cs_n), 64'd0);
        check("rd_setup_addr", 64'(flash_address), 64'h000100);
        observe(0, 0, 32'hDEADBEEF, 1'b0, lat, en_cyc, n_en, en_mask, n_hold_low, wseen);
        check("rd_latency", 64'(lat), 64'd7);
        check("rd_pulse_cycle", 64'(en_cyc), 64'd2);
        check("rd_pulse_kind", 64'(en_mask), 64'(3'b001));
        check("rd_pulse_count", 64'(n_en), 64'd1);
        check("rd_rsp_id", 64'(rsp_id), 64'd0);
        check("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        check("rd_err", 64'(rsp_err), 64'd0);
        check("rd_done_cs", 64'(flash_cs_n), 64'd1);
        tick();

        // Both requesters valid from reset with writes: grants alternate 0,1,0,1
        reset_n = 1'b0;
        req_valid = 2'b11; req_op0 = 2'b01; req_op1 = 2'b01;
        req_addr0 = 24'h00AA00; req_addr1 = 24'h00BB00;
        req_wdata0 = 32'h11111111; req_wdata1 = 32'h22222222;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            tick();
            observe(0, 0, 32'h0, 1'b0, lat, en_cyc, n_en, en_mask, n_hold_low, wseen);
            check($sformatf("rr_latency_%0d", k), 64'(lat), 64'd11);
            check($sformatf("rr_pulses_%0d", k), 64'(n_en), 64'd1);
            check($sformatf("rr_kind_%0d", k), 64'(en_mask), 64'(3'b010));
            check($sformatf("rr_wdata_%0d", k), 64'(wseen),
                  (k % 2 == 0) ? 64'h11111111 : 64'h22222222);
            check($sformatf("rr_id_%0d", k), 64'(rsp_id), 64'(k % 2));
            check($sformatf("rr_rdata_%0d", k), 64'(rsp_rdata), 64'd0);
            tick();
        end
        req_valid = '0;

        // Erase on requester 1 with hold_req high for 5 WAIT cycles
        req_valid = 2'b10; req_op1 = 2'b10; req_addr1 = 24'h010000;
        #1;
        check("er_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0;
        observe(10, 5, 32'h5A5A5A5A, 1'b0, lat, en_cyc, n_en, en_mask, n_hold_low, wseen);
        check("er_latency", 64'(lat), 64'd40);
        check("er_hold_low", 64'(n_hold_low), 64'd5);
        check("er_kind", 64'(en_mask), 64'(3'b100));
        check("er_id", 64'(rsp_id), 64'd1);
        check("er_rdata", 64'(rsp_rdata), 64'd0);
        tick();

        // Reserved op on requester 0; hold_req asserted outside WAIT
        req_valid = 2'b01; req_op0 = 2'b11; req_addr0 = 24'h123456;
        hold_req = 1'b1;
        #1;
        check("res_hold_n_idle", 64'(flash_hold_n), 64'd1);
        tick();
        req_valid = '0;
        hold_req = 1'b1;
        #1;
        check("res_rsp_valid", 64'(rsp_valid), 64'd1);
        check("res_err", 64'(rsp_err), 64'd1);
        check("res_rdata", 64'(rsp_rdata), 64'd0);
        check("res_cs_n", 64'(flash_cs_n), 64'd1);
        check("res_hold_n", 64'(flash_hold_n), 64'd1);
        check("res_enables", 64'({flash_erase_enable, flash_write_enable, flash_read_enable}), 64'd0);
        tick();
        hold_req = 1'b0;
        req_valid = 2'b01; req_op0 = 2'b00;
        #1;
        check("res_back_idle", 64'(req_ready), 64'(2'b01));
        req_valid = '0;
        #1;

        // Reset during WAIT of a write
        req_valid = 2'b01; req_op0 = 2'b01; req_wdata0 = 32'hCAFEF00D;
        tick();
        req_valid = '0;
        tick(); tick(); tick(); tick();
        check("abort_in_wait_cs", 64'(flash_cs_n), 64'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_cs_n", 64'(flash_cs_n), 64'd1);
        n_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) n_rsp++;
            tick();
        end
        check("abort_no_rsp", 64'(n_rsp), 64'd0);
        req_valid = 2'b10; req_op1 = 2'b00; req_addr1 = 24'h000200;
        tick();
        req_valid = '0;
        observe(0, 0, 32'h12345678, 1'b0, lat, en_cyc, n_en, en_mask, n_hold_low, wseen);
        check("abort_fresh_latency", 64'(lat), 64'd7);
        check("abort_fresh_rdata", 64'(rsp_rdata), 64'h12345678);
        check("abort_fresh_id", 64'(rsp_id), 64'd1);
        tick();

        // Write then read on requester 0 with flash_data_out changing every cycle
        req_valid = 2'b01; req_op0 = 2'b01; req_wdata0 = 32'h0BADC0DE;
        tick();
        req_valid = '0;
        observe(0, 0, 32'hB0000000, 1'b1, lat, en_cyc, n_en, en_mask, n_hold_low, wseen);
        check("wr_latency", 64'(lat), 64'd11);
        check("wr_rdata_zero", 64'(rsp_rdata), 64'd0);
        tick();
        req_valid = 2'b01; req_op0 = 2'b00;
        tick();
        req_valid = '0;
        observe(0, 0, 32'hA0000000, 1'b1, lat, en_cyc, n_en, en_mask, n_hold_low, wseen);
        check("rd2_latency", 64'(lat), 64'd7);
        check("rd2_rdata_last_wait", 64'(rsp_rdata), 64'hA0000006);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
